grey_pointer_rx: RTL
====================

# grey_pointer_rx

Receive side of a Gray-coded pointer link between two clock domains. Synchronises an incoming Gray-coded write pointer into the local clock, decodes it to binary, and tracks a local read pointer. It presents the pending item count with a take handshake to the consumer, and returns the read pointer Gray-encoded to the far side. It sits on the read side of every dual-clock FIFO and credit link in the design.

## Interface
- `WIDTH`, default 4: pointer width in bits; legal range 2..16; pointer space is 2^WIDTH.
- `SYNC`, default 2: number of synchroniser flops on `wr_grey_i`; legal minimum 2.
- `clk_i`  in  1  local clock; all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `wr_grey_i`  in  WIDTH  Gray-coded write pointer from the foreign domain; asynchronous to `clk_i`.
- `take_i`  in  1  consumer takes one item this cycle.
- `clr_i`  in  1  clears the sticky `underflow_o`.
- `valid_o`  out  1  at least one item pending.
- `pending_o`  out  WIDTH  number of pending items.
- `wr_bin_o`  out  WIDTH  decoded, synchronised write pointer.
- `rd_bin_o`  out  WIDTH  local read pointer, binary.
- `rd_grey_o`  out  WIDTH  local read pointer, Gray-coded, registered; goes back to the writer's domain.
- `underflow_o`  out  1  sticky: `take_i` was asserted while `valid_o` was 0.

## Operation
- **Synchroniser:** `SYNC`-deep flop chain on `wr_grey_i`. No logic between stages.
- **Decode:** the last sync stage feeds the combinational Gray-to-binary decode, b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i]. The result is registered into `wr_bin_o`.
- **Pending count:**
  - `pending_o` = (`wr_bin_o` − `rd_bin_o`) mod 2^WIDTH, combinational from registers.
  - `valid_o` = (`pending_o` != 0).
- **Take handshake:**
  - `take_i` && `valid_o`: `rd_bin_o` increments by 1 mod 2^WIDTH at the next edge, and `rd_grey_o` gets the Gray encoding of the new value at the same edge.
  - `take_i` && !`valid_o`: pointers unchanged; `underflow_o` is set at the next edge.
- **Underflow clear:** `clr_i` clears `underflow_o` at the next edge. If `clr_i` and a new underflow occur in the same cycle, set wins.
- **Pointer and occupancy rules:**
  - Pointers wrap modulo 2^WIDTH.
  - The maximum representable occupancy is 2^WIDTH − 1. The writer must keep occupancy at or below this using `rd_grey_o`; this block does not detect writer overrun.
  - Multi-step jumps of the sampled write pointer are legal, since the writer may run faster. `pending_o` simply grows by the jump.
- **Reset:** all sync flops, `wr_bin_o`, `rd_bin_o`, `rd_grey_o` and `underflow_o` go to 0; `valid_o` = 0 and `pending_o` = 0. The writer's pointer must also be reset to 0. If reset is asserted mid-operation, pending data is discarded.

## Timing
- Write-pointer latency:
  - A stable change on `wr_grey_i` before edge n is visible in the last sync stage after edge n+SYNC−1.
  - It reaches `wr_bin_o`, `pending_o` and `valid_o` after edge n+SYNC. That is SYNC+1 edges, 3 at the default.
- Take latency:
  - A take in cycle k updates `rd_bin_o`, `rd_grey_o`, `pending_o` and `valid_o` after edge k+1.
  - Back-to-back takes drain one item per cycle with no bubbles.
- Simultaneous events:
  - A take and a `wr_bin_o` update in the same edge are both applied: pending(next) = pending + Δwr − 1.
  - A take in the cycle `valid_o` first rises is accepted.
- Output registering:
  - `rd_grey_o` is driven directly from a flop, with no combinational path from `take_i`. This keeps it glitch-free for crossing.
  - `valid_o` and `pending_o` have no combinational path from `take_i`.

## Structure
- No shared package types. The legal ranges of `WIDTH` and `SYNC` are checked by an elaboration-time assertion; an illegal value must fail elaboration.
- One sub-module, `grey_decode`: combinational, parameterised `WIDTH`, Gray in, binary out. It is instantiated once after the synchroniser.
- The binary-to-Gray conversion for `rd_grey_o` is inline: g = b ^ (b >> 1).

## Test plan
- **Reset:** assert `rst_i` mid-stream with pending = 5 → all outputs 0 in the same cycle (async), and they stay 0 until the writer advances.
- **Single increment:** drive `wr_grey_i` through 0→1→3→2 (binary 0..3), one step every 4 cycles, with no takes → `wr_bin_o` steps 1, 2, 3, each exactly SYNC+1 edges after the input change; `pending_o` = 3; `valid_o` = 1.
- **Drain:** from pending = 3, hold `take_i` for 3 cycles → `rd_bin_o` goes 1, 2, 3; `rd_grey_o` goes 1, 3, 2; `valid_o` falls after the third edge.
- **Wrap-around, `WIDTH` = 4:**
  - Writer advances 0→20 (`wr_bin_o` = 4) while the reader has taken 14 (`rd_bin_o` = 14) → `pending_o` = 6.
  - Draining wraps `rd_grey_o` from 8 (binary 15) to 0 (binary 0).
- **Underflow:**
  - `take_i` with pending = 0 → `rd_bin_o` unchanged and `underflow_o` = 1 next edge.
  - `clr_i` alone clears it.
  - `clr_i` together with another empty take → `underflow_o` remains 1.
- **Simultaneous:** pending = 1, take in the same cycle the decoded pointer jumps by 3 → pending = 3 next edge.

Source files
------------

// File: rtl/grey_pointer_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grey_pointer_rx_pkg
// Description : Legal parameter ranges for the Gray pointer receiver.
//               Holds constants only; no types are shared across the link.
// Revision    : 1.0 - initial release
// ============================================================================
package grey_pointer_rx_pkg;

  localparam int c_WIDTH_MIN = 2;
  localparam int c_WIDTH_MAX = 16;
  localparam int c_SYNC_MIN  = 2;

endpackage
`default_nettype wire

// File: rtl/grey_pointer_rx_decode.sv
`default_nettype none
// ============================================================================
// Module      : grey_decode
// Description : Combinational Gray-to-binary decoder.
//               Each binary bit is the XOR of all Gray bits at or above it.
// Ports       : grey_i  in  WIDTH  Gray-coded value
//               bin_o   out WIDTH  binary value
// Revision    : 1.0 - initial release
// ============================================================================
module grey_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] grey_i,
  output logic [WIDTH-1:0] bin_o
);

  // Reduction form of b[i] = b[i+1] ^ g[i]; avoids a self-referencing
  // vector in a single combinational block.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^grey_i[WIDTH-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/grey_pointer_rx.sv
`default_nettype none
// ============================================================================
// Module      : grey_pointer_rx
// Description : Read side of a Gray-coded pointer clock-domain crossing.
//               Synchronises the foreign write pointer, decodes it, tracks a
//               local read pointer and returns it Gray-encoded.
// Ports       : clk_i        in   local clock
//               rst_i        in   asynchronous active-high reset
//               wr_grey_i    in   Gray write pointer (foreign domain)
//               take_i       in   consumer takes one item
//               clr_i        in   clear sticky underflow
//               valid_o      out  at least one item pending
//               pending_o    out  pending item count
//               wr_bin_o     out  synchronised, decoded write pointer
//               rd_bin_o     out  read pointer, binary
//               rd_grey_o    out  read pointer, Gray, registered
//               underflow_o  out  sticky take-while-empty flag
// Revision    : 1.0 - initial release
// ============================================================================
module grey_pointer_rx
  import grey_pointer_rx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SYNC  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wr_grey_i,
  input  logic             take_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pending_o,
  output logic [WIDTH-1:0] wr_bin_o,
  output logic [WIDTH-1:0] rd_bin_o,
  output logic [WIDTH-1:0] rd_grey_o,
  output logic             underflow_o
);

  if (WIDTH < c_WIDTH_MIN || WIDTH > c_WIDTH_MAX) begin : g_bad_width
    $error("grey_pointer_rx: WIDTH must be in 2..16");
  end
  if (SYNC < c_SYNC_MIN) begin : g_bad_sync
    $error("grey_pointer_rx: SYNC must be at least 2");
  end

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]           r_wr_bin;
  logic [WIDTH-1:0]           r_rd_bin;
  logic [WIDTH-1:0]           r_rd_grey;
  logic                       r_underflow;

  logic [WIDTH-1:0]           w_wr_bin;
  logic [WIDTH-1:0]           w_pending;
  logic                       w_valid;
  logic                       w_accept;
  logic                       w_empty_take;
  logic [WIDTH-1:0]           w_rd_next;

  // Plain flop chain: the first stage may go metastable, so nothing
  // combinational is allowed between stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= wr_grey_i;
      for (int i = 1; i < SYNC; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  grey_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .grey_i (r_sync[SYNC-1]),
    .bin_o  (w_wr_bin)
  );

  // Occupancy comes only from registers, so valid/pending never see take_i
  // combinationally.
  assign w_pending    = r_wr_bin - r_rd_bin;
  assign w_valid      = (w_pending != '0);
  assign w_accept     = take_i & w_valid;
  assign w_empty_take = take_i & ~w_valid;
  assign w_rd_next    = w_accept ? (r_rd_bin + c_ONE) : r_rd_bin;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_bin    <= '0;
      r_rd_bin    <= '0;
      r_rd_grey   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_bin  <= w_wr_bin;
      r_rd_bin  <= w_rd_next;
      // Encoded from the next binary value so the Gray flop changes on the
      // same edge as the binary pointer, one bit at a time.
      r_rd_grey <= w_rd_next ^ (w_rd_next >> 1);
      // A fresh underflow takes priority over a simultaneous clear.
      if (w_empty_take) begin
        r_underflow <= 1'b1;
      end else if (clr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign valid_o     = w_valid;
  assign pending_o   = w_pending;
  assign wr_bin_o    = r_wr_bin;
  assign rd_bin_o    = r_rd_bin;
  assign rd_grey_o   = r_rd_grey;
  assign underflow_o = r_underflow;

endmodule
`default_nettype wire
